// File: rtl/pipe_chain_pkg.sv
// Shared types for the pipeline latch chain: FSM encodings, latch select codes,
// and the function that picks each stage's hold/bubble/load action.
package pipe_chain_pkg;

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_HALT = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;

    // Chains longer than this are not supported by stage_sel.
    localparam int MAX_STAGES = 32;

    typedef enum logic [1:0] {
        S_RUN  = ST_RUN,
        S_HALT = ST_HALT,
        S_STEP = ST_STEP
    } state_e;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'b00,
        SEL_BUBBLE = 2'b01,
        SEL_LOAD   = 2'b10
    } sel_e;

    // A stage holds if it or any stage above it stalls; the stage just above
    // the highest stall gets a bubble. Flush beats everything while advancing.
    function automatic sel_e stage_sel(input logic [MAX_STAGES-1:0] stall,
                                       input logic [MAX_STAGES-1:0] flush,
                                       input logic                  adv,
                                       input int                    k);
        logic held;
        logic below;
        held  = 1'b0;
        below = 1'b0;
        for (int j = 0; j < MAX_STAGES; j++) begin
            if (j >= k && stall[j]) held = 1'b1;
            if (j == k - 1 && stall[j]) below = 1'b1;
        end
        if (!adv)     return SEL_HOLD;
        if (flush[k]) return SEL_BUBBLE;
        if (held)     return SEL_HOLD;
        if (below)    return SEL_BUBBLE;
        return SEL_LOAD;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Input handshake and latch-observation bus of the pipeline latch chain.
interface pipe_stage_chain_if #(
    parameter int NB_DATA   = 32,
    parameter int NB_STAGES = 4
);
    logic                         i_in_valid;
    logic [NB_DATA-1:0]           i_in_data;
    logic                         o_in_ready;
    logic [NB_STAGES-1:0]         o_stage_valid;
    logic [NB_STAGES*NB_DATA-1:0] o_stage_data;
    logic                         o_out_valid;
    logic [NB_DATA-1:0]           o_out_data;

    modport master (
        output i_in_valid, i_in_data,
        input  o_in_ready, o_stage_valid, o_stage_data, o_out_valid, o_out_data
    );

    modport slave (
        input  i_in_valid, i_in_data,
        output o_in_ready, o_stage_valid, o_stage_data, o_out_valid, o_out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline latch: valid bit plus payload, with hold / bubble / load select.
module pipe_stage_reg
    import pipe_chain_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  sel_e               i_sel,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_data
);
    logic               valid_q, valid_d;
    logic [NB_DATA-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        case (i_sel)
            SEL_BUBBLE: begin
                valid_d = 1'b0;
                data_d  = '0;
            end
            SEL_LOAD: begin
                valid_d = i_valid;
                data_d  = i_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline latch chain with stall/flush, debug RUN/HALT/STEP and counters.
// Define PIPE_CHAIN_BUBBLE_CNT_EN to build the bubble counter; otherwise o_bubble_cnt is 0.
module pipe_stage_chain
    import pipe_chain_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int NB_STAGES = 4,
    parameter int NB_CNT    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_dunit_clk_en,
    input  logic                 i_dunit_halt,
    input  logic                 i_dunit_run,
    input  logic                 i_dunit_step,
    input  logic [NB_STAGES-1:0] i_stall,
    input  logic [NB_STAGES-1:0] i_flush,
    pipe_stage_chain_if.slave    bus,
    output logic [1:0]           o_state,
    output logic [NB_CNT-1:0]    o_cycle_cnt,
    output logic [NB_CNT-1:0]    o_retire_cnt,
    output logic [NB_CNT-1:0]    o_bubble_cnt
);
    state_e state_q, state_d;
    logic   adv;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:  if (i_dunit_halt) state_d = S_HALT;
            S_HALT: begin
                if (i_dunit_run)       state_d = S_RUN;
                else if (i_dunit_step) state_d = S_STEP;
            end
            S_STEP: state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= S_RUN;
        else          state_q <= state_d;
    end

    // Halt is honoured in the cycle it is sampled, so a halting cycle never advances.
    assign adv = (state_q == S_RUN && i_dunit_clk_en && !i_dunit_halt) || (state_q == S_STEP);

    sel_e                              sel [NB_STAGES];
    logic [NB_STAGES-1:0]              stage_valid;
    logic [NB_STAGES-1:0][NB_DATA-1:0] stage_data;

    for (genvar gi = 0; gi < NB_STAGES; gi++) begin : g_stage
        logic               src_valid;
        logic [NB_DATA-1:0] src_data;

        assign sel[gi] = stage_sel(MAX_STAGES'(i_stall), MAX_STAGES'(i_flush), adv, gi);

        if (gi == 0) begin : g_head
            assign src_valid = bus.i_in_valid;
            assign src_data  = bus.i_in_data;
        end else begin : g_body
            assign src_valid = stage_valid[gi-1];
            assign src_data  = stage_data[gi-1];
        end

        pipe_stage_reg #(.NB_DATA(NB_DATA)) u_stage (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_sel   (sel[gi]),
            .i_valid (src_valid),
            .i_data  (src_data),
            .o_valid (stage_valid[gi]),
            .o_data  (stage_data[gi])
        );
    end

    logic [NB_CNT-1:0] cycle_q,  cycle_d;
    logic [NB_CNT-1:0] retire_q, retire_d;

    always_comb begin
        cycle_d  = cycle_q;
        retire_d = retire_q;
        if (adv && !(&cycle_q)) cycle_d = cycle_q + 1'b1;
        if (adv && stage_valid[NB_STAGES-1] && !i_stall[NB_STAGES-1] && !(&retire_q))
            retire_d = retire_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
        end
    end

`ifdef PIPE_CHAIN_BUBBLE_CNT_EN
    logic              any_bubble;
    logic [NB_CNT-1:0] bubble_q, bubble_d;

    always_comb begin
        any_bubble = 1'b0;
        for (int k = 0; k < NB_STAGES; k++)
            if (sel[k] == SEL_BUBBLE) any_bubble = 1'b1;
        bubble_d = bubble_q;
        if (any_bubble && !(&bubble_q)) bubble_d = bubble_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) bubble_q <= '0;
        else          bubble_q <= bubble_d;
    end

    assign o_bubble_cnt = bubble_q;
`else
    assign o_bubble_cnt = '0;
`endif

    assign bus.o_in_ready    = adv && (i_stall == '0) && !i_flush[0];
    assign bus.o_stage_valid = stage_valid;
    assign bus.o_stage_data  = stage_data;
    assign bus.o_out_valid   = stage_valid[NB_STAGES-1];
    assign bus.o_out_data    = stage_data[NB_STAGES-1];
    assign o_state           = state_q;
    assign o_cycle_cnt       = cycle_q;
    assign o_retire_cnt      = retire_q;
endmodule
